// File: rtl/bird_gravity_ctrl.sv
// Gravity timing for the bird column: a synchronised, edge-detected flap pulse
// and fall pulses whose spacing shrinks after each fall, with a hover window after each flap.
module bird_gravity_ctrl #(
  parameter int START_PERIOD = 50,
  parameter int MIN_PERIOD   = 10,
  parameter int STEP         = 8,
  parameter int HOVER        = 25,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key,
  input  logic             enable,
  output logic             flap,
  output logic             fall,
  output logic [CNT_W-1:0] period
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FALLING = 2'd1,
    ST_HOVER   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] START_P    = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] STEP_P     = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] HOVER_LAST = CNT_W'(HOVER - 1);
  localparam logic [CNT_W-1:0] ONE_P      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_P     = {CNT_W{1'b0}};
  // Compared one bit wider so MIN_PERIOD+STEP cannot overflow the period width.
  localparam logic [CNT_W:0]   SAT_LIM    = (CNT_W+1)'(MIN_PERIOD + STEP);

  state_t           state_r, state_s;
  logic             s1_r, s2_r, s3_r;
  logic             rise_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] period_r, period_s;
  logic [CNT_W-1:0] dec_period_s;
  logic             flap_r, flap_s;
  logic             fall_r, fall_s;

  // Key synchroniser plus previous-value flop for rise detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= key;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise_s = s2_r & ~s3_r;

  // Saturating period decrement, floored at MIN_PERIOD.
  always_comb begin
    dec_period_s = MIN_P;
    if ({1'b0, period_r} >= SAT_LIM) begin
      dec_period_s = period_r - STEP_P;
    end else begin
      dec_period_s = MIN_P;
    end
  end

  // Next-state logic: enable, then rise, then fall expiry, then hover expiry.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    period_s = period_r;
    flap_s   = 1'b0;
    fall_s   = 1'b0;
    if (!enable) begin
      state_s  = ST_IDLE;
      cnt_s    = ZERO_P;
      period_s = START_P;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s  = ST_FALLING;
          cnt_s    = ZERO_P;
          period_s = START_P;
        end
        ST_FALLING: begin
          if (rise_s) begin
            state_s  = ST_HOVER;
            cnt_s    = ZERO_P;
            period_s = START_P;
            flap_s   = 1'b1;
          end else if (cnt_r == period_r - ONE_P) begin
            cnt_s    = ZERO_P;
            period_s = dec_period_s;
            fall_s   = 1'b1;
          end else begin
            cnt_s = cnt_r + ONE_P;
          end
        end
        ST_HOVER: begin
          if (rise_s) begin
            cnt_s    = ZERO_P;
            period_s = START_P;
            flap_s   = 1'b1;
          end else if (cnt_r == HOVER_LAST) begin
            state_s = ST_FALLING;
            cnt_s   = ZERO_P;
          end else begin
            cnt_s = cnt_r + ONE_P;
          end
        end
        default: begin
          state_s  = ST_IDLE;
          cnt_s    = ZERO_P;
          period_s = START_P;
        end
      endcase
    end
  end

  // State, counter, period and output pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= ZERO_P;
      period_r <= START_P;
      flap_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      period_r <= period_s;
      flap_r   <= flap_s;
      fall_r   <= fall_s;
    end
  end

  assign flap   = flap_r;
  assign fall   = fall_r;
  assign period = period_r;

endmodule

// File: tb/tb_bird_gravity_ctrl.sv
// Directed bench for bird_gravity_ctrl with START_PERIOD=6, MIN_PERIOD=2, STEP=2, HOVER=4.
module tb_bird_gravity_ctrl;

  logic        clk;
  logic        reset;
  logic        key;
  logic        enable;
  logic        flap;
  logic        fall;
  logic [15:0] period;

  int tests;
  int failed;

  bird_gravity_ctrl #(
    .START_PERIOD(6),
    .MIN_PERIOD  (2),
    .STEP        (2),
    .HOVER       (4),
    .CNT_W       (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .enable(enable),
    .flap  (flap),
    .fall  (fall),
    .period(period)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset released mid-cycle; the next edge is the IDLE->FALLING entry (i=0).
  task automatic do_reset();
    reset  = 1'b0;
    key    = 1'b0;
    enable = 1'b1;
    step();
    #3;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    key    = 1'b0;
    enable = 1'b0;
    #1 reset = 1'b0;
    #1;
    tests++;
    if (flap !== 1'b0 || fall !== 1'b0 || period !== 16'd6) begin
      failed++;
      $display("FAIL reset_async flap=%b fall=%b period=%0d, want 0 0 6", flap, fall, period);
    end
    enable = 1'b1;
    key    = 1'b1;
    repeat (3) step();
    tests++;
    if (flap !== 1'b0 || fall !== 1'b0 || period !== 16'd6) begin
      failed++;
      $display("FAIL reset_held flap=%b fall=%b period=%0d, want 0 0 6", flap, fall, period);
    end
    key = 1'b0;
  endtask

  task automatic test_gravity();
    logic        ef, eg;
    logic [15:0] ep;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      step();
      ef = 1'b0;
      eg = (i == 6 || i == 10 || i == 12 || i == 14 || i == 16);
      ep = (i < 6) ? 16'd6 : (i < 10) ? 16'd4 : 16'd2;
      tests++;
      if (flap !== ef || fall !== eg || period !== ep) begin
        failed++;
        $display("FAIL gravity i=%0d got flap=%b fall=%b period=%0d, want %b %b %0d",
                 i, flap, fall, period, ef, eg, ep);
      end
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (flap !== 1'b0 || fall !== 1'b0 || period !== 16'd6) begin
      failed++;
      $display("FAIL reset_mid_fall flap=%b fall=%b period=%0d, want 0 0 6", flap, fall, period);
    end
  endtask

  task automatic test_flap_hold();
    logic        ef, eg;
    logic [15:0] ep;
    do_reset();
    for (int i = 0; i <= 24; i++) begin
      step();
      ef = (i == 4);
      eg = (i == 14 || i == 18 || i == 20 || i == 22 || i == 24);
      ep = (i < 14) ? 16'd6 : (i < 18) ? 16'd4 : 16'd2;
      tests++;
      if (flap !== ef || fall !== eg || period !== ep) begin
        failed++;
        $display("FAIL flap_hold i=%0d got flap=%b fall=%b period=%0d, want %b %b %0d",
                 i, flap, fall, period, ef, eg, ep);
      end
      if (i == 1) key = 1'b1;
      if (i == 21) key = 1'b0;
    end
  endtask

  task automatic test_rise_on_fall();
    logic        ef, eg;
    logic [15:0] ep;
    do_reset();
    for (int i = 0; i <= 22; i++) begin
      step();
      ef = (i == 10);
      eg = (i == 6 || i == 20);
      ep = (i < 6) ? 16'd6 : (i < 10) ? 16'd4 : (i < 20) ? 16'd6 : 16'd4;
      tests++;
      if (flap !== ef || fall !== eg || period !== ep) begin
        failed++;
        $display("FAIL rise_on_fall i=%0d got flap=%b fall=%b period=%0d, want %b %b %0d",
                 i, flap, fall, period, ef, eg, ep);
      end
      if (i == 7) key = 1'b1;
      if (i == 9) key = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic        ef, eg;
    logic [15:0] ep;
    do_reset();
    for (int i = 0; i <= 22; i++) begin
      step();
      ef = (i == 4 || i == 6);
      eg = (i == 16 || i == 20 || i == 22);
      ep = (i < 16) ? 16'd6 : (i < 20) ? 16'd4 : 16'd2;
      tests++;
      if (flap !== ef || fall !== eg || period !== ep) begin
        failed++;
        $display("FAIL back_to_back i=%0d got flap=%b fall=%b period=%0d, want %b %b %0d",
                 i, flap, fall, period, ef, eg, ep);
      end
      if (i == 1 || i == 3) key = 1'b1;
      if (i == 2 || i == 4) key = 1'b0;
    end
  endtask

  task automatic test_disable();
    logic        ef, eg;
    logic [15:0] ep;
    do_reset();
    for (int i = 0; i <= 30; i++) begin
      step();
      ef = 1'b0;
      eg = (i == 6 || i == 25 || i == 29);
      ep = (i < 6) ? 16'd6 : (i < 10) ? 16'd4 : (i < 25) ? 16'd6 : (i < 29) ? 16'd4 : 16'd2;
      tests++;
      if (flap !== ef || fall !== eg || period !== ep) begin
        failed++;
        $display("FAIL disable i=%0d got flap=%b fall=%b period=%0d, want %b %b %0d",
                 i, flap, fall, period, ef, eg, ep);
      end
      if (i == 9) enable = 1'b0;
      if (i == 11) key = 1'b1;
      if (i == 15) key = 1'b0;
      if (i == 18) enable = 1'b1;
    end
  endtask

  task automatic test_reset_hover();
    do_reset();
    for (int i = 0; i <= 4; i++) begin
      step();
      tests++;
      if (flap !== (i == 4) || fall !== 1'b0 || period !== 16'd6) begin
        failed++;
        $display("FAIL hover_pre i=%0d got flap=%b fall=%b period=%0d, want %b 0 6",
                 i, flap, fall, period, (i == 4));
      end
      if (i == 1) key = 1'b1;
      if (i == 3) key = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (flap !== 1'b0 || fall !== 1'b0 || period !== 16'd6) begin
      failed++;
      $display("FAIL reset_mid_hover flap=%b fall=%b period=%0d, want 0 0 6", flap, fall, period);
    end
    step();
    #3 reset = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      tests++;
      if (flap !== 1'b0 || fall !== (i == 6) || period !== ((i < 6) ? 16'd6 : 16'd4)) begin
        failed++;
        $display("FAIL after_hover_reset i=%0d got flap=%b fall=%b period=%0d, want 0 %b",
                 i, flap, fall, period, (i == 6));
      end
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_gravity();
    test_flap_hold();
    test_rise_on_fall();
    test_back_to_back();
    test_disable();
    test_reset_hover();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
